// File: rtl/dcache_dm_ctrl.sv
// rtl/dcache_dm_ctrl.sv - direct-mapped write-back data cache with miss-handling FSM
//
// Purpose: direct-mapped, write-back, write-allocate data cache placed between a
// CPU load/store port and a line-wide memory/L2 interface. A miss first writes
// back a dirty victim line (WB) and then refills the line (FILL); every access
// completes with a one-cycle cpu_ready pulse (RESP).
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cpu_req/we/addr/wdata/be      CPU access; held stable until cpu_ready
//   cpu_ready, cpu_rdata          completion pulse and registered load data
//   mem_req/we/addr/wline         registered line request (write-back or refill)
//   mem_rline, mem_ack            refill data and one-cycle request completion
//   hit_count, miss_count         wrapping lookup statistics
module dcache_dm_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 32,
  parameter int NUM_LINES  = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic [31:0]             cpu_wdata,
  input  logic [3:0]              cpu_be,
  output logic                    cpu_ready,
  output logic [31:0]             cpu_rdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [8*LINE_BYTES-1:0] mem_wline,
  input  logic [8*LINE_BYTES-1:0] mem_rline,
  input  logic                    mem_ack,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count
);

  localparam int OFFSET_W = $clog2(LINE_BYTES);
  localparam int INDEX_W  = $clog2(NUM_LINES);
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINE_W   = 8 * LINE_BYTES;
  localparam int WORDS    = LINE_BYTES / 4;
  localparam int WSEL_W   = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WB   = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [OFFSET_W-1:0] OFF_ZERO = '0;

  // Line storage; data and tags carry no reset, only valid/dirty do.
  logic [LINE_W-1:0]    data_mem [NUM_LINES];
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [NUM_LINES-1:0] valid;
  logic [NUM_LINES-1:0] dirty;

  logic [1:0]         state;
  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_idx;
  logic [WSEL_W-1:0]  req_word;
  logic               req_we;
  logic [31:0]        req_wdata;
  logic [3:0]         req_be;

  // Lookup on the live request; only consumed while IDLE.
  logic [TAG_W-1:0]   c_tag;
  logic [INDEX_W-1:0] c_idx;
  logic [WSEL_W-1:0]  c_word;
  logic [LINE_W-1:0]  c_line;
  logic               c_hit;
  logic               c_victim_dirty;
  logic               unused_addr_lsb;

  assign c_tag  = cpu_addr[ADDR_W-1 -: TAG_W];
  assign c_idx  = cpu_addr[OFFSET_W +: INDEX_W];
  assign c_line = data_mem[c_idx];
  assign c_hit  = valid[c_idx] && (tag_mem[c_idx] == c_tag);
  assign c_victim_dirty = valid[c_idx] && dirty[c_idx];
  assign unused_addr_lsb = ^cpu_addr[1:0];

  generate
    if (WORDS > 1) begin : g_word_sel
      assign c_word = cpu_addr[2 +: WSEL_W];
    end else begin : g_single_word
      assign c_word = '0;
    end
  endgenerate

  // Word k sits at the high end of the line for k = 0 (big-endian layout).
  function automatic logic [31:0] get_word(input logic [LINE_W-1:0] line,
                                           input logic [WSEL_W-1:0] w);
    int k;
    k = (WORDS > 1) ? int'(w) : 0;
    return line[LINE_W-1-32*k -: 32];
  endfunction

  function automatic logic [LINE_W-1:0] put_word(input logic [LINE_W-1:0] line,
                                                 input logic [WSEL_W-1:0] w,
                                                 input logic [31:0]       val);
    logic [LINE_W-1:0] r;
    int k;
    k = (WORDS > 1) ? int'(w) : 0;
    r = line;
    r[LINE_W-1-32*k -: 32] = val;
    return r;
  endfunction

  // be[b] guards wdata[8b+7:8b]; be[3] is the lowest byte address.
  function automatic logic [31:0] merge_word(input logic [31:0] old,
                                             input logic [31:0] wd,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

  // Control, status bits and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      valid      <= '0;
      dirty      <= '0;
      cpu_ready  <= 1'b0;
      cpu_rdata  <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wline  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_req) begin
            if (c_hit) begin
              hit_count <= hit_count + 32'd1;
              cpu_rdata <= get_word(c_line, c_word);
              cpu_ready <= 1'b1;
              if (cpu_we) dirty[c_idx] <= 1'b1;
              state <= S_RESP;
            end else begin
              miss_count <= miss_count + 32'd1;
              mem_req    <= 1'b1;
              if (c_victim_dirty) begin
                mem_we    <= 1'b1;
                mem_addr  <= {tag_mem[c_idx], c_idx, OFF_ZERO};
                mem_wline <= c_line;
                state     <= S_WB;
              end else begin
                mem_we   <= 1'b0;
                mem_addr <= {c_tag, c_idx, OFF_ZERO};
                state    <= S_FILL;
              end
            end
          end
        end
        S_WB: begin
          // mem_req stays high; the request turns into the refill in place.
          if (mem_ack) begin
            mem_we   <= 1'b0;
            mem_addr <= {req_tag, req_idx, OFF_ZERO};
            state    <= S_FILL;
          end
        end
        S_FILL: begin
          if (mem_ack) begin
            mem_req        <= 1'b0;
            valid[req_idx] <= 1'b1;
            dirty[req_idx] <= req_we;
            cpu_rdata      <= get_word(mem_rline, req_word);
            cpu_ready      <= 1'b1;
            state          <= S_RESP;
          end
        end
        S_RESP: begin
          cpu_ready <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Arrays and latched request fields; writes are suppressed during reset so
  // an abandoned refill leaves the line untouched.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_IDLE && cpu_req) begin
        req_tag   <= c_tag;
        req_idx   <= c_idx;
        req_word  <= c_word;
        req_we    <= cpu_we;
        req_wdata <= cpu_wdata;
        req_be    <= cpu_be;
        if (c_hit && cpu_we) begin
          data_mem[c_idx] <= put_word(c_line, c_word,
                                      merge_word(get_word(c_line, c_word), cpu_wdata, cpu_be));
        end
      end
      if (state == S_FILL && mem_ack) begin
        tag_mem[req_idx] <= req_tag;
        if (req_we) begin
          data_mem[req_idx] <= put_word(mem_rline, req_word,
                                        merge_word(get_word(mem_rline, req_word), req_wdata, req_be));
        end else begin
          data_mem[req_idx] <= mem_rline;
        end
      end
    end
  end

endmodule

// File: tb/tb_dcache_dm_ctrl.sv
// tb/tb_dcache_dm_ctrl.sv - self-checking bench for dcache_dm_ctrl against a memory-image model
module tb_dcache_dm_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_req;
  logic         cpu_we;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic [3:0]   cpu_be;
  logic         cpu_ready;
  logic [31:0]  cpu_rdata;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wline;
  logic [255:0] mem_rline;
  logic         mem_ack;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  always #5 clk = ~clk;

  dcache_dm_ctrl #(.ADDR_W(32), .LINE_BYTES(32), .NUM_LINES(256)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wline(mem_wline), .mem_rline(mem_rline), .mem_ack(mem_ack),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  int passed = 0;
  int total  = 0;

  // Reference: the true byte contents of every touched line, what the memory
  // side currently holds, and which line address each cache slot holds.
  logic [255:0] truth   [int unsigned];
  logic [255:0] backing [int unsigned];
  logic [31:0]  res_line  [256];
  bit           res_valid [256];
  bit           res_dirty [256];
  int           exp_hits   = 0;
  int           exp_misses = 0;

  // Memory requests observed during the last access.
  logic         q_we    [$];
  logic [31:0]  q_addr  [$];
  logic [255:0] q_wline [$];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Byte j of a line is at line address offset j; word k = bytes 4k..4k+3,
  // lowest address in the most significant byte.
  function automatic logic [31:0] line_word(input logic [255:0] l, input int k);
    logic [31:0] w;
    for (int b = 0; b < 4; b++) w[31-8*b -: 8] = l[255-8*(4*k+b) -: 8];
    return w;
  endfunction

  function automatic logic [255:0] line_store(input logic [255:0] l, input int k,
                                              input logic [31:0] wd, input logic [3:0] be);
    logic [255:0] r;
    r = l;
    for (int b = 0; b < 4; b++) begin
      if (be[3-b]) r[255-8*(4*k+b) -: 8] = wd[31-8*b -: 8];
    end
    return r;
  endfunction

  task automatic ensure_line(input logic [31:0] la);
    logic [255:0] l;
    if (!truth.exists(la)) begin
      l = rand_line();
      truth[la]   = l;
      backing[la] = l;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      if (res_valid[i] && res_dirty[i]) truth[res_line[i]] = backing[res_line[i]];
      res_valid[i] = 0;
      res_dirty[i] = 0;
    end
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  // Drive one access from IDLE, act as the memory, return load data and cycle count.
  task automatic access(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                        input logic [3:0] be, input int dmin, input int dmax,
                        output logic [31:0] rd, output int cyc);
    int n;
    int d;
    logic done;
    logic w0;
    logic [31:0] a0;
    q_we.delete(); q_addr.delete(); q_wline.delete();
    rd = '0;
    cpu_addr = addr; cpu_we = we; cpu_wdata = wd; cpu_be = be; cpu_req = 1'b1;
    done = 1'b0;
    @(posedge clk); @(negedge clk); n = 1;
    while (!done && n < 200) begin
      if (cpu_ready) begin
        done = 1'b1;
        rd = cpu_rdata;
      end else if (mem_req) begin
        a0 = mem_addr; w0 = mem_we;
        q_we.push_back(mem_we); q_addr.push_back(mem_addr); q_wline.push_back(mem_wline);
        d = $urandom_range(dmax, dmin);
        for (int i = 0; i < d; i++) begin
          @(posedge clk); @(negedge clk); n++;
          chk("stall_mem_req", mem_req, 1'b1);
          chk("stall_mem_addr", mem_addr, a0);
          chk("stall_mem_we", mem_we, w0);
          chk("stall_cpu_ready", cpu_ready, 1'b0);
        end
        mem_rline = w0 ? rand_line() : (backing.exists(a0) ? backing[a0] : rand_line());
        mem_ack = 1'b1;
        @(posedge clk); @(negedge clk); n++;
        mem_ack = 1'b0;
        mem_rline = rand_line();
        if (!w0) begin
          chk("fill_ack_to_ready", cpu_ready, 1'b1);
          chk("fill_ack_req_drop", mem_req, 1'b0);
        end
      end else begin
        @(posedge clk); @(negedge clk); n++;
      end
    end
    chk("ready_within_budget", done, 1'b1);
    cyc = n;
    cpu_req = 1'b0;
    // A stray ack while responding must be ignored.
    if ($urandom_range(0, 3) == 0) mem_ack = 1'b1;
    @(posedge clk); @(negedge clk);
    mem_ack = 1'b0;
    chk("ready_one_cycle", cpu_ready, 1'b0);
    chk("idle_no_mem_req", mem_req, 1'b0);
  endtask

  // Access plus full comparison against the reference model.
  task automatic run(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                     input logic [3:0] be, input int dmin, input int dmax,
                     output logic [31:0] rd);
    logic [31:0]  la;
    int           idx;
    int           k;
    int           cyc;
    bit           hit;
    logic [31:0]  exp_rd;
    logic         e_we    [$];
    logic [31:0]  e_addr  [$];
    logic [255:0] e_wline [$];
    la  = addr & 32'hFFFF_FFE0;
    idx = int'((addr >> 5) & 32'hFF);
    k   = int'((addr >> 2) & 32'h7);
    ensure_line(la);
    hit = res_valid[idx] && (res_line[idx] == la);
    if (!hit) begin
      if (res_valid[idx] && res_dirty[idx]) begin
        e_we.push_back(1'b1); e_addr.push_back(res_line[idx]); e_wline.push_back(truth[res_line[idx]]);
      end
      e_we.push_back(1'b0); e_addr.push_back(la); e_wline.push_back('0);
      exp_misses++;
    end else begin
      exp_hits++;
    end
    exp_rd = line_word(truth[la], k);

    access(addr, we, wd, be, dmin, dmax, rd, cyc);

    chk("mem_req_count", q_addr.size(), e_addr.size());
    for (int i = 0; i < e_addr.size() && i < q_addr.size(); i++) begin
      chk("mem_we", q_we[i], e_we[i]);
      chk("mem_addr", q_addr[i], e_addr[i]);
      if (e_we[i]) chk("mem_wline", q_wline[i], e_wline[i]);
    end
    chk("cpu_rdata", rd, exp_rd);
    if (hit) chk("hit_latency", cyc, 1);
    chk("hit_count", hit_count, exp_hits);
    chk("miss_count", miss_count, exp_misses);

    if (!hit && res_valid[idx] && res_dirty[idx]) backing[res_line[idx]] = truth[res_line[idx]];
    if (we) truth[la] = line_store(truth[la], k, wd, be);
    res_dirty[idx] = (hit ? res_dirty[idx] : 1'b0) | we;
    res_line[idx]  = la;
    res_valid[idx] = 1'b1;
  endtask

  initial begin
    logic [31:0]  rd;
    logic [255:0] pat;
    logic [31:0]  a;

    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
    mem_ack = 1'b0; mem_rline = '0;
    for (int i = 0; i < 256; i++) begin res_valid[i] = 0; res_dirty[i] = 0; res_line[i] = '0; end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_cpu_ready", cpu_ready, 1'b0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_hit_count", hit_count, 32'h0);
    chk("rst_miss_count", miss_count, 32'h0);

    pat = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
           32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
    truth[32'h2000] = pat; backing[32'h2000] = pat;

    run(32'h0000_2004, 1'b0, 32'h0, 4'h0, 0, 2, rd);
    chk("first_load_rdata", rd, 32'h22222222);
    chk("first_load_fill_addr", q_addr.size() > 0 ? q_addr[0] : 32'hDEAD_BEEF, 32'h0000_2000);
    chk("first_load_miss", miss_count, 32'd1);

    run(32'h0000_2004, 1'b0, 32'h0, 4'h0, 0, 0, rd);
    chk("reload_rdata", rd, 32'h22222222);
    chk("reload_hit", hit_count, 32'd1);
    chk("reload_no_mem", q_addr.size(), 0);

    run(32'h0000_2008, 1'b1, 32'hAABBCCDD, 4'b1001, 0, 0, rd);
    run(32'h0000_2008, 1'b0, 32'h0, 4'h0, 0, 0, rd);
    chk("merged_word", rd, 32'hAA3333DD);

    run(32'h0000_4008, 1'b0, 32'h0, 4'h0, 1, 3, rd);
    chk("evict_req_count", q_addr.size(), 2);
    if (q_addr.size() == 2) begin
      chk("evict_wb_we", q_we[0], 1'b1);
      chk("evict_wb_addr", q_addr[0], 32'h0000_2000);
      a = line_word(q_wline[0], 2);
      chk("evict_wb_word2", a, 32'hAA3333DD);
      chk("evict_fill_addr", q_addr[1], 32'h0000_4000);
    end

    run(32'h0000_6000, 1'b0, 32'h0, 4'h0, 10, 10, rd);

    ensure_line(32'h0000_8000);
    cpu_addr = 32'h0000_8004; cpu_we = 1'b0; cpu_req = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("abort_fill_req", mem_req, 1'b1);
    chk("abort_fill_addr", mem_addr, 32'h0000_8000);
    repeat (2) @(negedge clk);
    rst = 1'b1; cpu_req = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("abort_mem_req", mem_req, 1'b0);
    chk("abort_cpu_ready", cpu_ready, 1'b0);
    chk("abort_hit_count", hit_count, 32'h0);
    chk("abort_miss_count", miss_count, 32'h0);
    model_reset();
    run(32'h0000_8004, 1'b0, 32'h0, 4'h0, 0, 1, rd);
    chk("post_reset_misses", miss_count, 32'd1);

    for (int i = 0; i < 300; i++) begin
      a = ($urandom_range(0, 3) << 13) | ($urandom_range(0, 3) << 5) |
          ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      run(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), 0, 3, rd);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
